multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style main control FSM for the multi-cycle RISC-V core variant. It sits directly upstream of ALU control: it decodes the opcode, produces the 2-bit ALUOp, and sequences datapath muxes and write enables over several cycles per instruction. It supports lw, sw, R-type (add/sub/and/or) and beq, and handshakes with a shared instruction/data memory through MemReady.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  rising-edge clock; only clock.
- rst  in  1  asynchronous, active-high reset.
- Op  in  7  instruction[6:0], taken from the instruction register.
- Zero  in  1  ALU zero flag, valid in the BEQ state.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register and OldPC enable.
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 register A.
- ALUSrcB  out  2  00 register B, 01 ImmExt, 10 constant 4.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 reserved (drives 00).
- RegWrite  out  1  register file write enable.
- ALUOp  out  2  to ALU control: 00 add, 01 subtract, 10 use funct fields.
- IllegalInstr  out  1  one-cycle pulse for an unsupported opcode.
- State  out  4  current state encoding, for debug and the bench.

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, beq 1100011. Any other opcode is illegal.
- ImmSrc is combinational from Op in every state: lw→00, sw→01, beq→10, other→00.
- Outputs not listed for a state are 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=MemReady. Stay while !MemReady, else →DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state:
  - lw/sw →MEMADR
  - R →EXECUTER
  - beq →BEQ
  - other →ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw →MEMREAD, sw →MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay while !MemReady, else →MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 →FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until MemReady. →FETCH on MemReady.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 →ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 →FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero →FETCH.
- ILLEGAL: IllegalInstr=1 →FETCH. No architectural write occurs.
- ALUOp=11 is never driven.

## Timing
- State register updates on the clk rising edge. All outputs decode from State (plus MemReady/Zero gating where listed); no output registers.
- Reset: State=FETCH immediately on rst rise, regardless of clock.
  - While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and IllegalInstr are forced 0.
  - The other outputs take their FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00.
- Reset mid-instruction abandons it at once. A partially asserted MemWrite drops asynchronously.
- Latency with MemReady constantly 1, in cycles from FETCH entry to the next FETCH entry:
  - lw 5
  - sw 4
  - R 4
  - beq 3
  - illegal 3
- Each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle. There is no timeout.
- MemReady is ignored in all other states.
- Zero is sampled only in BEQ. A taken branch loads the PC at the BEQ→FETCH edge.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants
  - the state enum (FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, BEQ=8, ILLEGAL=9)
  - ALUOp, ImmSrc, ALUSrcA/B and ResultSrc encodings, also used by ALU control and the datapath.
- One natural sub-module, imm_src_decode: the combinational Op→ImmSrc map, reused by the single-cycle decoder.
- Top: state register, next-state logic, output decode.

## Test plan
- Reset: assert rst mid-MEMWRITE with MemWrite=1 → MemWrite=0 and State=0 asynchronously. Release with MemReady=1 → IRWrite=PCWrite=1 in the first cycle.
- lw, MemReady=1: Op=0000011 → State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01. ImmSrc=00 throughout.
- sw with memory stall: Op=0100011, MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 cycles, 7 cycles total, ImmSrc=01, RegWrite never 1.
- R-type: Op=0110011 → ALUOp=10 in EXECUTER, RegWrite=1 with ResultSrc=00 in ALUWB, 4 cycles.
- beq: Op=1100011 with Zero=1 → PCWrite=1 in BEQ with ALUOp=01. Repeat with Zero=0 → PCWrite=0. Both take 3 cycles.
- Illegal: Op=0010011 → ILLEGAL for 1 cycle with IllegalInstr=1, no RegWrite/MemWrite, then FETCH. Fetch stall with MemReady=0 for 2 cycles → IRWrite stays 0 until MemReady=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path (control FSM, ALU control, datapath).
package riscv_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;

  // Supported opcodes
  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

  // Main control FSM states
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ILLEGAL  = 4'd9
  } state_e;

  // ALUOp to ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/imm_src_decode.sv
// Opcode to immediate-format map; shared with the single-cycle decoder.
module imm_src_decode
  import riscv_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  output logic [1:0]      o_imm_src
);

  // Pure opcode lookup; unsupported opcodes fall back to the I format
  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_LW:   o_imm_src = IMM_I;
      OP_SW:   o_imm_src = IMM_S;
      OP_BEQ:  o_imm_src = IMM_B;
      default: o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multi-cycle core: sequences lw/sw/R/beq with MemReady handshake.
module multicycle_control
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    Op,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [1:0]         ALUOp,
  output logic               IllegalInstr,
  output logic [STATE_W-1:0] State
);

  state_e r_state;
  state_e w_next;

  imm_src_decode u_imm_src_decode (
    .i_op      (Op),
    .o_imm_src (ImmSrc)
  );

  assign State = STATE_W'(r_state);

  // State register; reset lands in FETCH without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state and Moore output decode; write strobes are masked while reset is held
  always_comb begin
    w_next       = r_state;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REGB;
    RegWrite     = 1'b0;
    ALUOp        = ALUOP_ADD;
    IllegalInstr = 1'b0;

    case (r_state)
      S_FETCH: begin
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURES;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        if (Op == OP_LW)      w_next = S_MEMREAD;
        else if (Op == OP_SW) w_next = S_MEMWRITE;
        else                  w_next = S_FETCH;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemWrite  = 1'b1;
        if (MemReady) w_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_REGB;
        ALUOp   = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_REGA;
        ALUSrcB   = SRCB_REGB;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = Zero;
        w_next    = S_FETCH;
      end
      S_ILLEGAL: begin
        IllegalInstr = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    if (rst) begin
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      MemWrite     = 1'b0;
      RegWrite     = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver queues per-cycle expectations, monitor checks at negedge.
module tb_multicycle_control;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_ILL = 7'b0010011;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic       rw;
    logic [1:0] aop;
    logic       ill;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [6:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
  logic [3:0] State;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t  exp_q[$];
  string name_q[$];

  multicycle_control dut (
    .clk          (clk),
    .rst          (rst),
    .Op           (Op),
    .Zero         (Zero),
    .MemReady     (MemReady),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ImmSrc       (ImmSrc),
    .RegWrite     (RegWrite),
    .ALUOp        (ALUOp),
    .IllegalInstr (IllegalInstr),
    .State        (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for a hand-chosen state and the inputs applied in that cycle
  function automatic exp_t model(input logic [3:0] st, input logic [6:0] op,
                                 input logic mr, input logic z, input logic r);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.imm = (op == T_SW) ? 2'b01 : (op == T_BEQ) ? 2'b10 : 2'b00;
    case (st)
      4'd0: begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
      4'd1: begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2: begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3: begin e.adr = 1'b1; end
      4'd4: begin e.rs = 2'b01; e.rw = 1'b1; end
      4'd5: begin e.adr = 1'b1; e.mw = 1'b1; end
      4'd6: begin e.sa = 2'b10; e.aop = 2'b10; end
      4'd7: begin e.rw = 1'b1; end
      4'd8: begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z; end
      4'd9: begin e.ill = 1'b1; end
      default: ;
    endcase
    if (r) begin
      e.pcw = 1'b0; e.irw = 1'b0; e.mw = 1'b0; e.rw = 1'b0; e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g = '{st: State, pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite,
          rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB, imm: ImmSrc, rw: RegWrite,
          aop: ALUOp, ill: IllegalInstr};
    return g;
  endfunction

  task automatic check(input string nm, input exp_t e);
    exp_t g;
    g = sample();
    n_chk++;
    if (g === e) n_pass++;
    else $display("FAIL %s t=%0t got=%h expected=%h (state got %0d exp %0d)",
                  nm, $time, g, e, g.st, e.st);
  endtask

  // Monitor: every queued expectation is compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) check(name_q.pop_front(), exp_q.pop_front());
  end

  // One clock cycle of stimulus: apply inputs, queue expectation, advance to just past the edge
  task automatic cyc(input string nm, input logic [3:0] st, input logic mr, input logic z);
    MemReady = mr;
    Zero     = z;
    exp_q.push_back(model(st, Op, mr, z, 1'b0));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; Op = T_LW; Zero = 1'b0; MemReady = 1'b1;
    #2;
    check("reset_async", model(4'd0, Op, 1'b1, 1'b0, 1'b1));
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", model(4'd0, Op, 1'b1, 1'b0, 1'b1));
    rst = 1'b0;

    // lw, no stalls: 0,1,2,3,4
    Op = T_LW;
    cyc("lw_fetch",   4'd0, 1'b1, 1'b0);
    cyc("lw_decode",  4'd1, 1'b1, 1'b0);
    cyc("lw_memadr",  4'd2, 1'b1, 1'b0);
    cyc("lw_memread", 4'd3, 1'b1, 1'b0);
    cyc("lw_memwb",   4'd4, 1'b1, 1'b0);

    // sw with three stall cycles in MEMWRITE
    Op = T_SW;
    cyc("sw_fetch",   4'd0, 1'b1, 1'b0);
    cyc("sw_decode",  4'd1, 1'b1, 1'b0);
    cyc("sw_memadr",  4'd2, 1'b1, 1'b0);
    cyc("sw_stall0",  4'd5, 1'b0, 1'b0);
    cyc("sw_stall1",  4'd5, 1'b0, 1'b0);
    cyc("sw_stall2",  4'd5, 1'b0, 1'b0);
    cyc("sw_memwr",   4'd5, 1'b1, 1'b0);

    // R-type
    Op = T_R;
    cyc("r_fetch",    4'd0, 1'b1, 1'b0);
    cyc("r_decode",   4'd1, 1'b1, 1'b0);
    cyc("r_exec",     4'd6, 1'b1, 1'b0);
    cyc("r_aluwb",    4'd7, 1'b1, 1'b0);

    // beq taken then not taken
    Op = T_BEQ;
    cyc("beq1_fetch", 4'd0, 1'b1, 1'b0);
    cyc("beq1_dec",   4'd1, 1'b1, 1'b0);
    cyc("beq1_taken", 4'd8, 1'b1, 1'b1);
    cyc("beq0_fetch", 4'd0, 1'b1, 1'b1);
    cyc("beq0_dec",   4'd1, 1'b1, 1'b1);
    cyc("beq0_nt",    4'd8, 1'b1, 1'b0);

    // illegal opcode
    Op = T_ILL;
    cyc("ill_fetch",  4'd0, 1'b1, 1'b0);
    cyc("ill_decode", 4'd1, 1'b1, 1'b0);
    cyc("ill_pulse",  4'd9, 1'b1, 1'b0);

    // fetch stall, MemReady ignored outside memory states
    Op = T_R;
    cyc("fst_stall0", 4'd0, 1'b0, 1'b0);
    cyc("fst_stall1", 4'd0, 1'b0, 1'b0);
    cyc("fst_fetch",  4'd0, 1'b1, 1'b0);
    cyc("fst_decode", 4'd1, 1'b0, 1'b0);
    cyc("fst_exec",   4'd6, 1'b0, 1'b0);
    cyc("fst_aluwb",  4'd7, 1'b0, 1'b0);

    // reset asserted mid-MEMWRITE
    Op = T_SW;
    cyc("rsw_fetch",  4'd0, 1'b1, 1'b0);
    cyc("rsw_decode", 4'd1, 1'b1, 1'b0);
    cyc("rsw_memadr", 4'd2, 1'b1, 1'b0);
    MemReady = 1'b0;
    #1;
    check("rsw_memwrite", model(4'd5, Op, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    check("rsw_async_drop", model(4'd0, Op, 1'b0, 1'b0, 1'b1));
    MemReady = 1'b1;
    @(posedge clk); #1;
    check("rsw_held", model(4'd0, Op, 1'b1, 1'b0, 1'b1));
    rst = 1'b0;
    cyc("rel_fetch",  4'd0, 1'b1, 1'b0);
    cyc("rel_decode", 4'd1, 1'b1, 1'b0);

    @(posedge clk); #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
